// File: rtl/slow_clock_stepper.sv
// Fast-domain stepper: synchronises a divided slow clock, emits one step pulse per rising edge
// for a programmed burst length, measures the slow period and aborts on a stalled slow clock.
module slow_clock_stepper #(
  parameter int unsigned STEP_W   = 16,
  parameter int unsigned PERIOD_W = 28,
  parameter int unsigned TIMEOUT  = 8000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                slow_clock,
  input  logic                start,
  input  logic [STEP_W-1:0]   num_steps,
  output logic                step_pulse,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [STEP_W-1:0]   steps_left,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int unsigned WdW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e                state_q, state_d;
  logic [2:0]            sync_q;
  logic                  rise;
  logic [STEP_W-1:0]     steps_q, steps_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic                  timeout_q, timeout_d;
  logic                  step_q, step_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic                  valid_q, valid_d;
  logic                  armed_q, armed_d;

  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d   = state_q;
    steps_d   = steps_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    step_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          steps_d   = num_steps;
          timeout_d = 1'b0;
          wd_d      = '0;
          state_d   = (num_steps == '0) ? StFinish : StRun;
        end
      end
      StRun: begin
        // A rise in the expiry cycle still counts and re-arms the watchdog.
        if (rise) begin
          step_d  = 1'b1;
          steps_d = steps_q - STEP_W'(1);
          wd_d    = '0;
          if (steps_q == STEP_W'(1)) state_d = StFinish;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_comb begin
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + PERIOD_W'(1);
    period_d = period_q;
    valid_d  = valid_q;
    armed_d  = armed_q;
    if (rise) begin
      cnt_d = '0;
      // The first rise after reset only starts the measurement window.
      if (!armed_q) begin
        armed_d = 1'b1;
      end else begin
        period_d = (cnt_q == '1) ? cnt_q : cnt_q + PERIOD_W'(1);
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      steps_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[1:0], slow_clock};
      steps_q   <= steps_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      step_q    <= step_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      armed_q   <= armed_d;
    end
  end

  assign step_pulse   = step_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign steps_left   = steps_q;
  assign period       = period_q;
  assign period_valid = valid_q;

endmodule

// File: tb/tb_slow_clock_stepper.sv
// Self-checking bench for slow_clock_stepper: step pulses are predicted into a scoreboard
// (expected cycle and remaining count) and matched by a negedge monitor.
module tb_slow_clock_stepper;

  localparam int unsigned STEP_W   = 16;
  localparam int unsigned PERIOD_W = 28;
  localparam int unsigned TIMEOUT  = 32;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                slow_clock = 1'b0;
  logic                start = 1'b0;
  logic [STEP_W-1:0]   num_steps = '0;
  logic                step_pulse;
  logic                busy;
  logic                done;
  logic                timeout;
  logic [STEP_W-1:0]   steps_left;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;

  slow_clock_stepper #(
    .STEP_W   (STEP_W),
    .PERIOD_W (PERIOD_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .slow_clock   (slow_clock),
    .start        (start),
    .num_steps    (num_steps),
    .step_pulse   (step_pulse),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .steps_left   (steps_left),
    .period       (period),
    .period_valid (period_valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int                at;
    logic [STEP_W-1:0] left;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Every step pulse must match the oldest prediction in cycle and remaining count.
  always @(negedge clock) begin
    if (!reset && step_pulse === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_step: got pulse at cycle %0d steps_left %0d, required none",
                 cyc, steps_left);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.at || steps_left !== e.left)
          $display("FAIL step: got cycle %0d left %0d, required cycle %0d left %0d",
                   cyc, steps_left, e.at, e.left);
        else
          n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Low for 5 cycles, then high; a step (if expected) lands 3 cycles after the high drive.
  task automatic rise_slow(input logic [STEP_W-1:0] left, input logic expect_step,
                           output int mark);
    slow_clock = 1'b0;
    tick(5);
    mark = cyc;
    if (expect_step) sb.push_back('{at: cyc + 3, left: left});
    slow_clock = 1'b1;
  endtask

  task automatic wait_done(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic accept(input logic [STEP_W-1:0] n);
    num_steps = n;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    slow_clock = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    accept(16'd5);
    n_checks++;
    if (busy !== 1'b1 || steps_left !== 16'd5)
      $display("FAIL pre_reset_accept: busy %0b left %0d, required busy 1 left 5", busy, steps_left);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({step_pulse, busy, done, timeout, steps_left, period, period_valid} !== '0)
      $display("FAIL async_reset: busy %0b left %0d done %0b timeout %0b, required all 0",
               busy, steps_left, done, timeout);
    else n_pass++;
    slow_clock = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(8);
    n_checks++;
    if (period_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL release_high: period_valid %0b busy %0b, required 0 0", period_valid, busy);
    else n_pass++;
  endtask

  task automatic test_normal_burst;
    int m;
    int at;
    accept(16'd3);
    n_checks++;
    if (steps_left !== 16'd3 || busy !== 1'b1)
      $display("FAIL burst_accept: left %0d busy %0b, required 3 1", steps_left, busy);
    else n_pass++;
    rise_slow(16'd2, 1'b1, m);
    tick(5);
    rise_slow(16'd1, 1'b1, m);
    tick(5);
    rise_slow(16'd0, 1'b1, m);
    wait_done(10, at);
    n_checks++;
    if (at !== m + 4)
      $display("FAIL burst_done: got cycle %0d, required %0d", at, m + 4);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || steps_left !== 16'd0)
      $display("FAIL burst_end: busy %0b left %0d, required 0 0", busy, steps_left);
    else n_pass++;
    n_checks++;
    if (period !== 28'd10 || period_valid !== 1'b1)
      $display("FAIL period: got %0d valid %0b, required 10 1", period, period_valid);
    else n_pass++;
    tick(2);
  endtask

  task automatic test_zero_burst;
    slow_clock = 1'b0;
    tick(3);
    accept(16'd0);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL zero_c1: busy %0b done %0b, required 1 0", busy, done);
    else n_pass++;
    tick(1);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1)
      $display("FAIL zero_c2: busy %0b done %0b, required 0 1", busy, done);
    else n_pass++;
    tick(1);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL zero_c3: busy %0b done %0b, required 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int c;
    int at;
    int m;
    bit saw_done;
    slow_clock = 1'b0;
    tick(3);
    accept(16'd2);
    c        = cyc;
    at       = -1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (done === 1'b1) saw_done = 1'b1;
      if (timeout === 1'b1) begin
        at = cyc;
        break;
      end
    end
    n_checks++;
    if (at !== c + TIMEOUT)
      $display("FAIL timeout_time: got cycle %0d, required %0d", at, c + TIMEOUT);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || steps_left !== 16'd2 || saw_done)
      $display("FAIL timeout_state: busy %0b left %0d done_seen %0b, required 0 2 0",
               busy, steps_left, saw_done);
    else n_pass++;
    accept(16'd1);
    n_checks++;
    if (timeout !== 1'b0 || busy !== 1'b1 || steps_left !== 16'd1)
      $display("FAIL timeout_clear: timeout %0b busy %0b left %0d, required 0 1 1",
               timeout, busy, steps_left);
    else n_pass++;
    rise_slow(16'd0, 1'b1, m);
    wait_done(10, at);
    n_checks++;
    if (at !== m + 4 || timeout !== 1'b0)
      $display("FAIL retry_done: got cycle %0d timeout %0b, required %0d 0", at, timeout, m + 4);
    else n_pass++;
    tick(2);
  endtask

  task automatic test_start_while_busy;
    int m;
    int at;
    accept(16'd2);
    rise_slow(16'd1, 1'b1, m);
    tick(5);
    accept(16'd9);
    n_checks++;
    if (steps_left !== 16'd1 || busy !== 1'b1)
      $display("FAIL busy_start: left %0d busy %0b, required 1 1", steps_left, busy);
    else n_pass++;
    rise_slow(16'd0, 1'b1, m);
    wait_done(10, at);
    n_checks++;
    if (at !== m + 4 || steps_left !== 16'd0)
      $display("FAIL busy_done: got cycle %0d left %0d, required %0d 0", at, steps_left, m + 4);
    else n_pass++;
    tick(2);
  endtask

  task automatic test_back_to_back;
    num_steps = 16'd0;
    start     = 1'b1;
    tick(1);
    tick(1);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL b2b_done: done %0b busy %0b, required 1 0", done, busy);
    else n_pass++;
    tick(1);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_reaccept: busy %0b done %0b, required 1 0", busy, done);
    else n_pass++;
    start = 1'b0;
    tick(3);
  endtask

  task automatic test_reset_mid_burst;
    int m;
    int at;
    accept(16'd4);
    rise_slow(16'd3, 1'b1, m);
    tick(3);
    n_checks++;
    if (step_pulse !== 1'b1 || steps_left !== 16'd3)
      $display("FAIL mid_step: pulse %0b left %0d, required 1 3", step_pulse, steps_left);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || steps_left !== 16'd0 || step_pulse !== 1'b0)
      $display("FAIL mid_reset: busy %0b left %0d pulse %0b, required 0 0 0",
               busy, steps_left, step_pulse);
    else n_pass++;
    slow_clock = 1'b0;
    tick(2);
    reset = 1'b0;
    wait_done(12, at);
    n_checks++;
    if (at !== -1 || busy !== 1'b0)
      $display("FAIL post_reset: done at %0d busy %0b, required none 0", at, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_normal_burst();
    test_zero_burst();
    test_timeout();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_burst();
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL missing_steps: %0d predicted pulses never seen, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/slow_clock_stepper.md
# slow_clock_stepper

Fast-domain consumer of a divided `slow_clock`. It samples the toggling slow clock as data, detects its rising edges, and issues a burst of exactly `num_steps` single-cycle step pulses, one per slow-clock rising edge, for the cube-turning motor sequencer. It also measures the slow-clock period and aborts with a sticky timeout if the slow clock stalls mid-burst. It sits between the clock divider and the move/motor controller, all in the `clock` domain.

## Interface
- `STEP_W`, 16: width of `num_steps` and `steps_left`.
- `PERIOD_W`, 28: width of the period counter and `period`.
- `TIMEOUT`, 8000000: maximum number of `clock` cycles in RUN without a rise event before the burst aborts. Must be ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `slow_clock`  in  1  divided clock, sampled as asynchronous data.
- `start`  in  1  request a burst; honoured only in IDLE.
- `num_steps`  in  STEP_W  burst length, latched when `start` is accepted.
- `step_pulse`  out  1  one-cycle pulse per counted rise event.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `timeout`  out  1  sticky abort flag; cleared by the next accepted start.
- `steps_left`  out  STEP_W  remaining steps.
- `period`  out  PERIOD_W  `clock` cycles between the last two rise events.
- `period_valid`  out  1  high once `period` holds a real measurement.

## Operation
- **Synchroniser and edge detect**
  - Three flops, s1→s2→s3, all reset to 0.
  - Rise event `rise = s2 & ~s3`.
  - If `slow_clock` is high at reset release, this produces one rise event. That event only arms period measurement; it never produces a step, because the FSM is in IDLE.
- **FSM states: IDLE, RUN, FINISH**
  - IDLE & `start`:
    - Latch `steps_left <= num_steps`, clear `timeout`, clear watchdog.
    - Next state is FINISH if `num_steps == 0`, else RUN.
  - RUN & `rise`:
    - `step_pulse <= 1` and `steps_left <= steps_left - 1`.
    - If `steps_left == 1`, go to FINISH.
    - Clear watchdog.
  - RUN & no `rise`:
    - Increment watchdog.
    - If watchdog reaches `TIMEOUT-1`: set `timeout <= 1` and go to IDLE.
    - On timeout, `steps_left` holds its remaining count and `done` is not pulsed.
  - FINISH: `done <= 1` for exactly one cycle, then go to IDLE.
  - `start` outside IDLE is ignored, with no side effects.
  - Rise events in IDLE or FINISH produce no `step_pulse`.
- **Period measurement** (independent of FSM state)
  - A free counter increments every cycle and saturates at all-ones.
  - First rise after reset: clears the counter only (arming).
  - Each later rise: `period <= counter + 1`, saturating; clear the counter; `period_valid <= 1`.
- All outputs are registered.

## Timing
- **Reset values:** all outputs 0, state IDLE, `period_valid` 0. Reset acts immediately (asynchronously), including mid-burst.
- **Rise latency:** if `slow_clock` is first sampled high at edge k, `step_pulse` is high for the cycle after edge k+2.
- **Start acceptance:** `busy` rises at the edge after `start` is sampled.
- **Completion:**
  - `done` is high one cycle after the final `step_pulse`.
  - `busy` falls together with `done`, at the edge that ends FINISH.
- **`num_steps = 0`:** `done` pulses in the second cycle after acceptance; `busy` is high for 1 cycle.
- **Timeout:** `timeout` and `busy = 0` appear at the edge `TIMEOUT` cycles after acceptance or after the last rise.
- **Simultaneous rise and watchdog expiry:** the rise wins and the watchdog clears.
- **Back-to-back bursts:** `start` held high is re-accepted at the first IDLE cycle after FINISH.

## Test plan
- **Reset values:** assert `reset` asynchronously between clock edges → every output reads 0 immediately. Release with `slow_clock = 1` → no `step_pulse` and `period_valid = 0`.
- **Normal burst:** `slow_clock` period 10 cycles, `num_steps = 3`, pulse `start` → 3 `step_pulse`s spaced 10 cycles apart; `steps_left` goes 3→2→1→0; `done` one cycle after the third pulse. After the second measured rise, `period = 10` and `period_valid = 1`.
- **Zero-length burst:** `num_steps = 0` → `busy` high for one cycle, `done` pulses, zero `step_pulse`s.
- **Stalled slow clock:** `TIMEOUT = 32`, `slow_clock` held low, `num_steps = 2` → `timeout = 1` and `busy = 0` exactly 32 cycles after acceptance; no `done`; `steps_left = 2`. Then `start` with `num_steps = 1` → `timeout` clears and the burst completes.
- **Start while busy:** `start` pulsed mid-burst with `num_steps = 9` → ignored; the original count completes unchanged.
- **Reset mid-burst:** assert `reset` during RUN after 1 of 4 steps → `busy`, `steps_left` and `step_pulse` go to 0 at once; no `done` after release.
